axi4_sim_mem: RTL and testbench

Behavioural AXI4 slave memory that backs the chiplink bridge's memory port in SoC simulation. It accepts AXI4 read and write bursts (64-bit data, 4-bit IDs, 31-bit byte address) and serves them from an internal word array. The read channel and the write channel each run their own state machine, and each channel handles one transaction at a time.

---
 rtl/axi4_sim_mem_if.sv | 68 ++++++
 rtl/axi4_sim_mem.sv | 175 +++++++++++++++++
 tb/tb_axi4_sim_mem.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_sim_mem_if.sv
// AXI4 bus bundle for the simulation memory: 64-bit data, 4-bit IDs, 31-bit byte address.
interface axi4_sim_mem_if;
    logic        io_axi4_0_awvalid;
    logic        io_axi4_0_awready;
    logic [3:0]  io_axi4_0_awid;
    logic [30:0] io_axi4_0_awaddr;
    logic [7:0]  io_axi4_0_awlen;
    logic [2:0]  io_axi4_0_awsize;
    logic [1:0]  io_axi4_0_awburst;

    logic        io_axi4_0_wvalid;
    logic        io_axi4_0_wready;
    logic [63:0] io_axi4_0_wdata;
    logic [7:0]  io_axi4_0_wstrb;
    logic        io_axi4_0_wlast;

    logic        io_axi4_0_bvalid;
    logic        io_axi4_0_bready;
    logic [3:0]  io_axi4_0_bid;
    logic [1:0]  io_axi4_0_bresp;

    logic        io_axi4_0_arvalid;
    logic        io_axi4_0_arready;
    logic [3:0]  io_axi4_0_arid;
    logic [30:0] io_axi4_0_araddr;
    logic [7:0]  io_axi4_0_arlen;
    logic [2:0]  io_axi4_0_arsize;
    logic [1:0]  io_axi4_0_arburst;

    logic        io_axi4_0_rvalid;
    logic        io_axi4_0_rready;
    logic [3:0]  io_axi4_0_rid;
    logic [63:0] io_axi4_0_rdata;
    logic [1:0]  io_axi4_0_rresp;
    logic        io_axi4_0_rlast;

    modport slave (
        input  io_axi4_0_awvalid, io_axi4_0_awid, io_axi4_0_awaddr, io_axi4_0_awlen,
               io_axi4_0_awsize, io_axi4_0_awburst,
        output io_axi4_0_awready,
        input  io_axi4_0_wvalid, io_axi4_0_wdata, io_axi4_0_wstrb, io_axi4_0_wlast,
        output io_axi4_0_wready,
        output io_axi4_0_bvalid, io_axi4_0_bid, io_axi4_0_bresp,
        input  io_axi4_0_bready,
        input  io_axi4_0_arvalid, io_axi4_0_arid, io_axi4_0_araddr, io_axi4_0_arlen,
               io_axi4_0_arsize, io_axi4_0_arburst,
        output io_axi4_0_arready,
        output io_axi4_0_rvalid, io_axi4_0_rid, io_axi4_0_rdata, io_axi4_0_rresp,
               io_axi4_0_rlast,
        input  io_axi4_0_rready
    );

    modport master (
        output io_axi4_0_awvalid, io_axi4_0_awid, io_axi4_0_awaddr, io_axi4_0_awlen,
               io_axi4_0_awsize, io_axi4_0_awburst,
        input  io_axi4_0_awready,
        output io_axi4_0_wvalid, io_axi4_0_wdata, io_axi4_0_wstrb, io_axi4_0_wlast,
        input  io_axi4_0_wready,
        input  io_axi4_0_bvalid, io_axi4_0_bid, io_axi4_0_bresp,
        output io_axi4_0_bready,
        output io_axi4_0_arvalid, io_axi4_0_arid, io_axi4_0_araddr, io_axi4_0_arlen,
               io_axi4_0_arsize, io_axi4_0_arburst,
        input  io_axi4_0_arready,
        input  io_axi4_0_rvalid, io_axi4_0_rid, io_axi4_0_rdata, io_axi4_0_rresp,
               io_axi4_0_rlast,
        output io_axi4_0_rready
    );
endinterface

// File: rtl/axi4_sim_mem.sv
// Behavioural AXI4 slave memory: independent single-transaction read and write FSMs
// serving bursts from one word array that aliases across the whole address space.
module axi4_sim_mem #(
    parameter int    DEPTH_WORDS = 8192,
    parameter string INIT_FILE   = ""
) (
    input  logic           clk,
    input  logic           rst_n,
    axi4_sim_mem_if.slave  axi
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [63:0] mem [DEPTH_WORDS];

    function automatic logic [30:0] next_addr(input logic [30:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [30:0] step;
        logic [30:0] wrap_mask;
        step      = 31'd1 << size;
        wrap_mask = (({23'd0, len} + 31'd1) << size) - 31'd1;
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default: next_addr = addr + step;
        endcase
    endfunction

    // ---------------- write channel ----------------
    w_state_t    w_state_reg, w_state_next;
    logic [3:0]  aw_id_reg;
    logic [30:0] aw_addr_reg;
    logic [7:0]  aw_len_reg, w_cnt_reg;
    logic [2:0]  aw_size_reg;
    logic [1:0]  aw_burst_reg;
    logic        aw_hs, w_hs;
    logic [63:0] w_mask;

    for (genvar gi = 0; gi < 8; gi++) begin : g_wmask
        assign w_mask[gi*8 +: 8] = {8{axi.io_axi4_0_wstrb[gi]}};
    end

    always_comb begin
        w_state_next          = w_state_reg;
        axi.io_axi4_0_awready = 1'b0;
        axi.io_axi4_0_wready  = 1'b0;
        axi.io_axi4_0_bvalid  = 1'b0;
        axi.io_axi4_0_bid     = 4'd0;
        axi.io_axi4_0_bresp   = 2'b00;
        case (w_state_reg)
            W_IDLE: begin
                axi.io_axi4_0_awready = 1'b1;
                if (axi.io_axi4_0_awvalid) w_state_next = W_DATA;
            end
            W_DATA: begin
                axi.io_axi4_0_wready = 1'b1;
                // burst length comes from the beat counter alone; wlast is not trusted
                if (axi.io_axi4_0_wvalid && w_cnt_reg == aw_len_reg) w_state_next = W_RESP;
            end
            W_RESP: begin
                axi.io_axi4_0_bvalid = 1'b1;
                axi.io_axi4_0_bid    = aw_id_reg;
                if (axi.io_axi4_0_bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
        if (!rst_n) begin
            w_state_next          = W_IDLE;
            axi.io_axi4_0_awready = 1'b0;
            axi.io_axi4_0_wready  = 1'b0;
            axi.io_axi4_0_bvalid  = 1'b0;
            axi.io_axi4_0_bid     = 4'd0;
        end
    end

    assign aw_hs = axi.io_axi4_0_awvalid && axi.io_axi4_0_awready;
    assign w_hs  = axi.io_axi4_0_wvalid  && axi.io_axi4_0_wready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_reg <= W_IDLE;
            w_cnt_reg   <= 8'd0;
            aw_id_reg   <= 4'd0;
        end else begin
            w_state_reg <= w_state_next;
            if (aw_hs) begin
                aw_id_reg    <= axi.io_axi4_0_awid;
                aw_addr_reg  <= axi.io_axi4_0_awaddr;
                aw_len_reg   <= axi.io_axi4_0_awlen;
                aw_size_reg  <= axi.io_axi4_0_awsize;
                aw_burst_reg <= axi.io_axi4_0_awburst;
                w_cnt_reg    <= 8'd0;
            end else if (w_hs) begin
                w_cnt_reg   <= w_cnt_reg + 8'd1;
                aw_addr_reg <= next_addr(aw_addr_reg, aw_len_reg, aw_size_reg, aw_burst_reg);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs)
            mem[aw_addr_reg[3 +: IDX_W]] <= (mem[aw_addr_reg[3 +: IDX_W]] & ~w_mask)
                                          | (axi.io_axi4_0_wdata & w_mask);
    end

    // ---------------- read channel ----------------
    r_state_t    r_state_reg, r_state_next;
    logic [3:0]  ar_id_reg;
    logic [30:0] ar_addr_reg;
    logic [7:0]  ar_len_reg, r_cnt_reg;
    logic [2:0]  ar_size_reg;
    logic [1:0]  ar_burst_reg;
    logic        ar_hs, r_hs;

    always_comb begin
        r_state_next          = r_state_reg;
        axi.io_axi4_0_arready = 1'b0;
        axi.io_axi4_0_rvalid  = 1'b0;
        axi.io_axi4_0_rlast   = 1'b0;
        axi.io_axi4_0_rid     = 4'd0;
        axi.io_axi4_0_rresp   = 2'b00;
        case (r_state_reg)
            R_IDLE: begin
                axi.io_axi4_0_arready = 1'b1;
                if (axi.io_axi4_0_arvalid) r_state_next = R_DATA;
            end
            R_DATA: begin
                axi.io_axi4_0_rvalid = 1'b1;
                axi.io_axi4_0_rid    = ar_id_reg;
                axi.io_axi4_0_rlast  = (r_cnt_reg == ar_len_reg);
                if (axi.io_axi4_0_rready && r_cnt_reg == ar_len_reg) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
        if (!rst_n) begin
            r_state_next          = R_IDLE;
            axi.io_axi4_0_arready = 1'b0;
            axi.io_axi4_0_rvalid  = 1'b0;
            axi.io_axi4_0_rlast   = 1'b0;
            axi.io_axi4_0_rid     = 4'd0;
        end
    end

    // Asynchronous array read: a same-cycle write to this word is seen only next cycle.
    assign axi.io_axi4_0_rdata = mem[ar_addr_reg[3 +: IDX_W]];

    assign ar_hs = axi.io_axi4_0_arvalid && axi.io_axi4_0_arready;
    assign r_hs  = axi.io_axi4_0_rvalid  && axi.io_axi4_0_rready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_reg <= R_IDLE;
            r_cnt_reg   <= 8'd0;
            ar_id_reg   <= 4'd0;
        end else begin
            r_state_reg <= r_state_next;
            if (ar_hs) begin
                ar_id_reg    <= axi.io_axi4_0_arid;
                ar_addr_reg  <= axi.io_axi4_0_araddr;
                ar_len_reg   <= axi.io_axi4_0_arlen;
                ar_size_reg  <= axi.io_axi4_0_arsize;
                ar_burst_reg <= axi.io_axi4_0_arburst;
                r_cnt_reg    <= 8'd0;
            end else if (r_hs) begin
                r_cnt_reg   <= r_cnt_reg + 8'd1;
                ar_addr_reg <= next_addr(ar_addr_reg, ar_len_reg, ar_size_reg, ar_burst_reg);
            end
        end
    end

    logic unused_sigs;
    assign unused_sigs = axi.io_axi4_0_wlast;
endmodule

// File: tb/tb_axi4_sim_mem.sv
// Randomized bench for axi4_sim_mem, checked against an associative-array memory model
// that computes each beat address in closed form from the burst parameters.
module tb_axi4_sim_mem;
    localparam int DEPTH = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_sim_mem_if bus();

    axi4_sim_mem #(.DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .axi   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] model [int];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [30:0] beat_addr(input logic [30:0] a, input int len, input int size,
                                              input int burst, input int i);
        longint unsigned step, wl, base, aa;
        step = 64'd1 << size;
        aa   = 64'(a);
        if (burst == 0) return a;
        if (burst == 2) begin
            wl   = 64'(len + 1) * step;
            base = aa - (aa % wl);
            return 31'(base + ((aa - base + 64'(i) * step) % wl));
        end
        return 31'(aa + 64'(i) * step);
    endfunction

    function automatic int widx(input logic [30:0] a);
        return int'((a >> 3) % DEPTH);
    endfunction

    task automatic model_write(input logic [30:0] a, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] t;
        t = model.exists(widx(a)) ? model[widx(a)] : 64'd0;
        for (int k = 0; k < 8; k++) if (s[k]) t[k*8 +: 8] = d[k*8 +: 8];
        model[widx(a)] = t;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [30:0] addr, input int len,
                         input int size, input int burst);
        bus.io_axi4_0_awvalid = 1'b1;
        bus.io_axi4_0_awid    = id;
        bus.io_axi4_0_awaddr  = addr;
        bus.io_axi4_0_awlen   = 8'(len);
        bus.io_axi4_0_awsize  = 3'(size);
        bus.io_axi4_0_awburst = 2'(burst);
        for (int t = 0; t < 50 && bus.io_axi4_0_awready !== 1'b1; t++) @(negedge clk);
        if (bus.io_axi4_0_awready !== 1'b1) chk("aw_timeout", 0, 1);
        @(negedge clk);
        bus.io_axi4_0_awvalid = 1'b0;
        chk("aw_to_wready", 64'(bus.io_axi4_0_wready), 1);
    endtask

    task automatic do_w(input logic [30:0] a, input logic [63:0] d, input logic [7:0] s,
                        input bit last);
        bus.io_axi4_0_wvalid = 1'b1;
        bus.io_axi4_0_wdata  = d;
        bus.io_axi4_0_wstrb  = s;
        bus.io_axi4_0_wlast  = last;
        for (int t = 0; t < 50 && bus.io_axi4_0_wready !== 1'b1; t++) @(negedge clk);
        if (bus.io_axi4_0_wready !== 1'b1) chk("w_timeout", 0, 1);
        else model_write(a, d, s);
        @(negedge clk);
        bus.io_axi4_0_wvalid = 1'b0;
        bus.io_axi4_0_wlast  = 1'b0;
    endtask

    task automatic do_b(input logic [3:0] id, input bit rnd);
        chk("w_to_bvalid", 64'(bus.io_axi4_0_bvalid), 1);
        chk("aw_blocked", 64'(bus.io_axi4_0_awready), 0);
        if (rnd) begin
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                chk("b_held", 64'(bus.io_axi4_0_bvalid), 1);
            end
        end
        chk("bid", 64'(bus.io_axi4_0_bid), 64'(id));
        chk("bresp", 64'(bus.io_axi4_0_bresp), 0);
        bus.io_axi4_0_bready = 1'b1;
        @(negedge clk);
        bus.io_axi4_0_bready = 1'b0;
        chk("b_to_idle", 64'(bus.io_axi4_0_awready), 1);
    endtask

    // wd/ws hold the beat data and strobes for the burst
    task automatic axi_write(input logic [3:0] id, input logic [30:0] addr, input int len,
                             input int size, input int burst, input bit rnd);
        do_aw(id, addr, len, size, burst);
        for (int b = 0; b <= len; b++) begin
            if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
            do_w(beat_addr(addr, len, size, burst, b), wd[b], ws[b], b == len);
        end
        do_b(id, rnd);
        $display("WR id=%0d addr=%h len=%0d size=%0d burst=%0d", id, addr, len, size, burst);
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [30:0] addr, input int len,
                            input int size, input int burst, input bit rnd,
                            output logic [63:0] last_data);
        int beat;
        int cyc;
        logic [63:0] exp;
        last_data = 64'd0;
        bus.io_axi4_0_arvalid = 1'b1;
        bus.io_axi4_0_arid    = id;
        bus.io_axi4_0_araddr  = addr;
        bus.io_axi4_0_arlen   = 8'(len);
        bus.io_axi4_0_arsize  = 3'(size);
        bus.io_axi4_0_arburst = 2'(burst);
        for (int t = 0; t < 50 && bus.io_axi4_0_arready !== 1'b1; t++) @(negedge clk);
        if (bus.io_axi4_0_arready !== 1'b1) chk("ar_timeout", 0, 1);
        @(negedge clk);
        bus.io_axi4_0_arvalid = 1'b0;
        chk("ar_to_rvalid", 64'(bus.io_axi4_0_rvalid), 1);
        beat = 0;
        cyc  = 0;
        while (beat <= len && cyc < 2000) begin
            bus.io_axi4_0_rready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (!rnd) chk("r_consec", 64'(bus.io_axi4_0_rvalid), 1);
            if (bus.io_axi4_0_rvalid === 1'b1 && bus.io_axi4_0_rready) begin
                exp = model[widx(beat_addr(addr, len, size, burst, beat))];
                chk("rdata", bus.io_axi4_0_rdata, exp);
                chk("rid", 64'(bus.io_axi4_0_rid), 64'(id));
                chk("rlast", 64'(bus.io_axi4_0_rlast), 64'(beat == len));
                chk("rresp", 64'(bus.io_axi4_0_rresp), 0);
                last_data = bus.io_axi4_0_rdata;
                beat++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.io_axi4_0_rready = 1'b0;
        if (beat <= len) chk("r_timeout", 0, 1);
        chk("r_to_idle", 64'(bus.io_axi4_0_arready), 1);
        $display("RD id=%0d addr=%h len=%0d size=%0d burst=%0d", id, addr, len, size, burst);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic [63:0] held;
        int len;
        int size;
        int burst;
        logic [30:0] addr;

        bus.io_axi4_0_awvalid = 1'b0; bus.io_axi4_0_awid = 4'd0; bus.io_axi4_0_awaddr = 31'd0;
        bus.io_axi4_0_awlen = 8'd0; bus.io_axi4_0_awsize = 3'd0; bus.io_axi4_0_awburst = 2'd0;
        bus.io_axi4_0_wvalid = 1'b0; bus.io_axi4_0_wdata = 64'd0; bus.io_axi4_0_wstrb = 8'd0;
        bus.io_axi4_0_wlast = 1'b0; bus.io_axi4_0_bready = 1'b0;
        bus.io_axi4_0_arvalid = 1'b0; bus.io_axi4_0_arid = 4'd0; bus.io_axi4_0_araddr = 31'd0;
        bus.io_axi4_0_arlen = 8'd0; bus.io_axi4_0_arsize = 3'd0; bus.io_axi4_0_arburst = 2'd0;
        bus.io_axi4_0_rready = 1'b0;

        // reset and idle
        repeat (4) begin
            @(negedge clk);
            chk("rst_outs", {56'd0, bus.io_axi4_0_awready, bus.io_axi4_0_wready, bus.io_axi4_0_bvalid,
                             bus.io_axi4_0_arready, bus.io_axi4_0_rvalid, bus.io_axi4_0_rlast,
                             bus.io_axi4_0_bresp != 2'd0, bus.io_axi4_0_rresp != 2'd0}, 0);
        end
        chk("rst_ids", {56'd0, bus.io_axi4_0_bid, bus.io_axi4_0_rid}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_awready", 64'(bus.io_axi4_0_awready), 1);
        chk("rel_arready", 64'(bus.io_axi4_0_arready), 1);

        // single-beat write then read
        wd[0] = 64'h0123456789ABCDEF; ws[0] = 8'hFF;
        axi_write(4'd5, 31'h40, 0, 3, 1, 1'b0);
        axi_read(4'd3, 31'h40, 0, 3, 1, 1'b0, rd);
        chk("single_const", rd, 64'h0123456789ABCDEF);

        // INCR burst, then WRAP read over the same words
        for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
        axi_write(4'd1, 31'h100, 3, 3, 1, 1'b0);
        axi_read(4'd2, 31'h100, 3, 3, 1, 1'b0, rd);
        chk("incr_last_const", rd, 64'd4);
        axi_read(4'd4, 31'h118, 3, 3, 2, 1'b0, rd);
        chk("wrap_last_const", rd, 64'd3);

        // byte strobe
        wd[0] = '1; ws[0] = 8'hFF;
        axi_write(4'd6, 31'h200, 0, 3, 1, 1'b0);
        wd[0] = 64'd0; ws[0] = 8'h0F;
        axi_write(4'd7, 31'h200, 0, 3, 1, 1'b0);
        axi_read(4'd8, 31'h200, 0, 3, 1, 1'b0, rd);
        chk("strb_const", rd, 64'hFFFFFFFF00000000);

        // prefill the random region with full-word data
        for (int i = 0; i < 256; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        axi_write(4'd9, 31'h1000, 255, 3, 1, 1'b0);
        for (int i = 0; i < 256; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        axi_write(4'd10, 31'h1800, 255, 3, 1, 1'b0);

        // backpressure: stall rready for 5 cycles mid-burst
        bus.io_axi4_0_arvalid = 1'b1; bus.io_axi4_0_arid = 4'd11; bus.io_axi4_0_araddr = 31'h1000;
        bus.io_axi4_0_arlen = 8'd7; bus.io_axi4_0_arsize = 3'd3; bus.io_axi4_0_arburst = 2'd1;
        @(negedge clk);
        bus.io_axi4_0_arvalid = 1'b0;
        bus.io_axi4_0_rready = 1'b1;
        repeat (3) @(negedge clk);
        bus.io_axi4_0_rready = 1'b0;
        held = model[widx(31'h1018)];
        for (int i = 0; i < 5; i++) begin
            chk("bp_rvalid", 64'(bus.io_axi4_0_rvalid), 1);
            chk("bp_rdata", bus.io_axi4_0_rdata, held);
            @(negedge clk);
        end
        bus.io_axi4_0_rready = 1'b1;
        for (int b = 3; b < 8; b++) begin
            chk("bp_resume", bus.io_axi4_0_rdata, model[widx(31'(32'h1000 + b * 8))]);
            chk("bp_rlast", 64'(bus.io_axi4_0_rlast), 64'(b == 7));
            @(negedge clk);
        end
        bus.io_axi4_0_rready = 1'b0;
        $display("RD id=11 addr=1000 len=7 with 5-cycle stall");

        // same-cycle read and write of one word: read beat sees old data, next beat sees new
        held = model[widx(31'h40)];
        bus.io_axi4_0_arvalid = 1'b1; bus.io_axi4_0_arid = 4'd12; bus.io_axi4_0_araddr = 31'h40;
        bus.io_axi4_0_arlen = 8'd1; bus.io_axi4_0_arsize = 3'd3; bus.io_axi4_0_arburst = 2'd0;
        @(negedge clk);
        bus.io_axi4_0_arvalid = 1'b0;
        do_aw(4'd13, 31'h40, 0, 3, 1);
        bus.io_axi4_0_rready = 1'b1;
        chk("rw_same_old", bus.io_axi4_0_rdata, held);
        do_w(31'h40, 64'hFEEDFACECAFEBEEF, 8'hFF, 1'b1);
        chk("rw_same_new", bus.io_axi4_0_rdata, 64'hFEEDFACECAFEBEEF);
        chk("rw_same_rlast", 64'(bus.io_axi4_0_rlast), 1);
        @(negedge clk);
        bus.io_axi4_0_rready = 1'b0;
        do_b(4'd13, 1'b0);
        $display("RW same-word id=12/13 addr=40");

        // randomized bursts, with aliasing through the upper address bits
        for (int it = 0; it < 16; it++) begin
            burst = int'($urandom_range(0, 3));
            size  = int'($urandom_range(0, 3));
            len   = (burst == 2) ? (1 << $urandom_range(1, 3)) - 1 : int'($urandom_range(0, 7));
            addr  = 31'(32'h1000 + $urandom_range(0, 32'hFC0) + ($urandom_range(0, 3) << 16));
            for (int i = 0; i <= len; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
            axi_write(4'($urandom), addr, len, size, burst, 1'b1);
            axi_read(4'($urandom), addr, len, size, burst, 1'b1, rd);
        end

        // reset during a write burst with a read burst also in flight
        bus.io_axi4_0_arvalid = 1'b1; bus.io_axi4_0_arid = 4'd14; bus.io_axi4_0_araddr = 31'h100;
        bus.io_axi4_0_arlen = 8'd3; bus.io_axi4_0_arsize = 3'd3; bus.io_axi4_0_arburst = 2'd1;
        @(negedge clk);
        bus.io_axi4_0_arvalid = 1'b0;
        do_aw(4'd15, 31'h300, 3, 3, 1);
        do_w(31'h300, 64'hAAAA0000AAAA0000, 8'hFF, 1'b0);
        do_w(31'h308, 64'h5555111155551111, 8'hFF, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_awready", 64'(bus.io_axi4_0_awready), 1);
        chk("midrst_arready", 64'(bus.io_axi4_0_arready), 1);
        chk("midrst_bvalid", 64'(bus.io_axi4_0_bvalid), 0);
        chk("midrst_rvalid", 64'(bus.io_axi4_0_rvalid), 0);
        chk("midrst_wready", 64'(bus.io_axi4_0_wready), 0);
        $display("RST mid-burst write id=15 addr=300");
        axi_read(4'd1, 31'h300, 1, 3, 1, 1'b0, rd);
        chk("midrst_beat1", rd, 64'h5555111155551111);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
